// File: rtl/alu_sched.sv
// Round-robin scheduler that shares one combinational ALU between two requesters.
// Define ALU_SCHED_ILLEGAL_CHK_EN to flag opcodes 4'hC-4'hF and force their result to zero.
module alu_sched #(
   parameter int unsigned FIRST_PORT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_ctrl,
   input  logic [7:0] req0_x,
   input  logic [7:0] req0_y,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_ctrl,
   input  logic [7:0] req1_x,
   input  logic [7:0] req1_y,
   output logic       rsp0_valid,
   input  logic       rsp0_ready,
   output logic [7:0] rsp0_out,
   output logic       rsp0_carry,
   output logic       rsp0_err,
   output logic       rsp1_valid,
   input  logic       rsp1_ready,
   output logic [7:0] rsp1_out,
   output logic       rsp1_carry,
   output logic       rsp1_err,
   output logic [3:0] alu_ctrl,
   output logic [7:0] alu_x,
   output logic [7:0] alu_y,
   input  logic [7:0] alu_out,
   input  logic       alu_carry,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t     state;
   logic       grant;
   logic       last_grant;
   logic       grant_sel;
   logic       accept;
   logic       rsp_hs;
   logic [3:0] op_ctrl;
   logic [7:0] op_x;
   logic [7:0] op_y;
   logic [7:0] res_out;
   logic       res_carry;
   logic       rsp0_valid_q;
   logic       rsp1_valid_q;
   logic       busy_q;
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
   logic       res_err;
`endif

   always_comb begin
      // NOTE: combinational logic uses blocking assignments with a default first, so no latch is inferred.
      grant_sel = 1'b0;
      if (req0_valid && req1_valid) grant_sel = ~last_grant;
      else if (req1_valid)          grant_sel = 1'b1;
   end

   assign req0_ready = (state == IDLE) && req0_valid && !grant_sel;
   assign req1_ready = (state == IDLE) && req1_valid &&  grant_sel;
   assign accept     = req0_ready || req1_ready;
   assign rsp_hs     = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);

   // NOTE: state uses non-blocking assignments; every register, including the operand and
   // result registers, is cleared on reset so the ALU inputs and responses are defined.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         grant        <= 1'b0;
         last_grant   <= (FIRST_PORT == 0);
         op_ctrl      <= 4'h0;
         op_x         <= 8'h00;
         op_y         <= 8'h00;
         res_out      <= 8'h00;
         res_carry    <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         busy_q       <= 1'b0;
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
         res_err      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_ctrl <= grant_sel ? req1_ctrl : req0_ctrl;
                  op_x    <= grant_sel ? req1_x    : req0_x;
                  op_y    <= grant_sel ? req1_y    : req0_y;
                  grant   <= grant_sel;
                  busy_q  <= 1'b1;
                  state   <= EXEC;
               end
            end
            EXEC: begin
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
               if (op_ctrl >= 4'hC) begin
                  res_out   <= 8'h00;
                  res_carry <= 1'b0;
                  res_err   <= 1'b1;
               end else begin
                  res_out   <= alu_out;
                  res_carry <= alu_carry;
                  res_err   <= 1'b0;
               end
`else
               res_out   <= alu_out;
               res_carry <= alu_carry;
`endif
               rsp0_valid_q <= !grant;
               rsp1_valid_q <= grant;
               state        <= RESP;
            end
            RESP: begin
               // Only the owning port's ready can complete the response.
               if (rsp_hs) begin
                  last_grant   <= grant;
                  rsp0_valid_q <= 1'b0;
                  rsp1_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign alu_ctrl   = op_ctrl;
   assign alu_x      = op_x;
   assign alu_y      = op_y;
   assign busy       = busy_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_out   = res_out;
   assign rsp1_out   = res_out;
   assign rsp0_carry = res_carry;
   assign rsp1_carry = res_carry;
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
   assign rsp0_err   = res_err;
   assign rsp1_err   = res_err;
`else
   assign rsp0_err   = 1'b0;
   assign rsp1_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: per-port request drivers, an ALU model, and a response monitor.
`timescale 1ns/1ps
module tb_alu_sched;

   typedef struct packed {
      logic [3:0] ctrl;
      logic [7:0] x;
      logic [7:0] y;
   } req_t;

   typedef struct packed {
      logic [7:0] out;
      logic       carry;
      logic       err;
   } res_t;

   logic       clk;
   logic       rst_n;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0] req0_ctrl, req1_ctrl;
   logic [7:0] req0_x, req0_y, req1_x, req1_y;
   logic       rsp0_valid, rsp0_ready, rsp0_carry, rsp0_err;
   logic       rsp1_valid, rsp1_ready, rsp1_carry, rsp1_err;
   logic [7:0] rsp0_out, rsp1_out;
   logic [3:0] alu_ctrl;
   logic [7:0] alu_x, alu_y, alu_out;
   logic       alu_carry;
   logic       busy;

   int   tests_run    = 0;
   int   tests_failed = 0;
   int   cyc          = 0;
   int   acc_count    = 0;
   req_t req_q0[$];
   req_t req_q1[$];
   res_t exp_q0[$];
   res_t exp_q1[$];
   int   grant_log[$];
   int   acc_cyc_log[$];
   int   acc_cycle[2];
   int   hs_cycle[2];
   int   rsp_count[2];
   res_t last_rsp[2];
   bit   prev_valid[2];

   alu_sched #(.FIRST_PORT(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
      .req0_x(req0_x), .req0_y(req0_y),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
      .req1_x(req1_x), .req1_y(req1_y),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_out(rsp0_out),
      .rsp0_carry(rsp0_carry), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_out(rsp1_out),
      .rsp1_carry(rsp1_carry), .rsp1_err(rsp1_err),
      .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
      .alu_out(alu_out), .alu_carry(alu_carry), .busy(busy)
   );

   // Shared ALU: 0 ADD, 1 SUB (borrow in bit 8), 2 AND, 3 OR, 4 XOR, 5 NOT x, 6 y>>x, 7 y<<x.
   function automatic logic [8:0] alu_model(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
      case (c)
         4'h0:    return {1'b0, a} + {1'b0, b};
         4'h1:    return {1'b0, a} - {1'b0, b};
         4'h2:    return {1'b0, a & b};
         4'h3:    return {1'b0, a | b};
         4'h4:    return {1'b0, a ^ b};
         4'h5:    return {1'b0, ~a};
         4'h6:    return {1'b0, b >> a[2:0]};
         4'h7:    return {1'b0, b << a[2:0]};
         default: return 9'h000;
      endcase
   endfunction

   assign {alu_carry, alu_out} = alu_model(alu_ctrl, alu_x, alu_y);

   function automatic res_t expect_of(input req_t r);
      logic [8:0] v;
      res_t       e;
      v = alu_model(r.ctrl, r.x, r.y);
      e = {v[7:0], v[8], 1'b0};
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
      if (r.ctrl >= 4'hC) e = {8'h00, 1'b0, 1'b1};
`endif
      return e;
   endfunction

   function automatic res_t illegal_expect();
`ifdef ALU_SCHED_ILLEGAL_CHK_EN
      return {8'h00, 1'b0, 1'b1};
`else
      return {8'h00, 1'b0, 1'b0};
`endif
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Request drivers: present the queue head from just after each rising edge.
   initial begin
      req0_valid = 1'b0; req0_ctrl = '0; req0_x = '0; req0_y = '0;
      forever begin
         @(posedge clk); #1;
         if (req_q0.size() > 0) begin
            req0_valid = 1'b1;
            {req0_ctrl, req0_x, req0_y} = req_q0[0];
         end else req0_valid = 1'b0;
      end
   end

   initial begin
      req1_valid = 1'b0; req1_ctrl = '0; req1_x = '0; req1_y = '0;
      forever begin
         @(posedge clk); #1;
         if (req_q1.size() > 0) begin
            req1_valid = 1'b1;
            {req1_ctrl, req1_x, req1_y} = req_q1[0];
         end else req1_valid = 1'b0;
      end
   end

   task automatic mon_port(input int p, input logic qv, input logic qr, input logic sv,
                           input logic sr, input logic [7:0] o, input logic c, input logic e);
      res_t got;
      res_t want;
      if (qv && qr) begin
         if (p == 0) begin
            if (req_q0.size() > 0) begin
               exp_q0.push_back(expect_of(req_q0[0]));
               void'(req_q0.pop_front());
            end
         end else if (req_q1.size() > 0) begin
            exp_q1.push_back(expect_of(req_q1[0]));
            void'(req_q1.pop_front());
         end
         grant_log.push_back(p);
         acc_cyc_log.push_back(cyc);
         acc_cycle[p] = cyc;
         acc_count++;
      end
      if (sv && !prev_valid[p]) begin
         tests_run++;
         if (cyc - acc_cycle[p] != 2) begin
            tests_failed++;
            $display("FAIL latency port%0d: got %0d cycles, want 2", p, cyc - acc_cycle[p]);
         end
      end
      if (sv && sr) begin
         got = {o, c, e};
         hs_cycle[p] = cyc;
         rsp_count[p]++;
         last_rsp[p] = got;
         tests_run++;
         if ((p == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            tests_failed++;
            $display("FAIL unexpected_rsp port%0d: got %h, want no response", p, got);
         end else begin
            want = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (got !== want) begin
               tests_failed++;
               $display("FAIL scoreboard port%0d: got %h, want %h", p, got, want);
            end
         end
      end
      prev_valid[p] = sv;
   endtask

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         mon_port(0, req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_out, rsp0_carry, rsp0_err);
         mon_port(1, req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_out, rsp1_carry, rsp1_err);
         if (req0_ready && req1_ready) begin
            tests_failed++;
            $display("FAIL dual_ready: got both ready, want at most one");
         end
         if (rsp0_valid && rsp1_valid) begin
            tests_failed++;
            $display("FAIL dual_valid: got both rsp valid, want at most one");
         end
      end else begin
         prev_valid[0] = 1'b0;
         prev_valid[1] = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic sample();
      @(negedge clk); #1;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((req_q0.size() > 0 || req_q1.size() > 0 || exp_q0.size() > 0 ||
              exp_q1.size() > 0 || busy) && n < budget) begin
         sample();
         n++;
      end
      tests_run++;
      if (n >= budget) begin
         tests_failed++;
         $display("FAIL drain_timeout: got %0d pending after %0d cycles, want 0",
                  req_q0.size() + req_q1.size() + exp_q0.size() + exp_q1.size(), budget);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      tick(); tick(); tick();
      sample();
      tests_run++;
      if ({busy, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp0_carry, rsp1_carry,
           req0_ready, req1_ready} !== 9'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b, want 000000000", {busy, rsp0_valid, rsp1_valid,
                  rsp0_err, rsp1_err, rsp0_carry, rsp1_carry, req0_ready, req1_ready});
      end
      tests_run++;
      if ({rsp0_out, rsp1_out} !== 16'h0000) begin
         tests_failed++;
         $display("FAIL reset_out: got %h, want 0000", {rsp0_out, rsp1_out});
      end
      tests_run++;
      if ({alu_ctrl, alu_x, alu_y} !== 20'h00000) begin
         tests_failed++;
         $display("FAIL reset_alu: got %h, want 00000", {alu_ctrl, alu_x, alu_y});
      end
      tick();
      rst_n = 1'b1;
      sample();
      tests_run++;
      if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 5'b0) begin
         tests_failed++;
         $display("FAIL idle_after_reset: got %b, want 00000",
                  {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready});
      end
   endtask

   task automatic test_single_op();
      int n0, n1;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      n0 = rsp_count[0]; n1 = rsp_count[1];
      req_q0.push_back({4'h0, 8'hFF, 8'h01});
      wait_drain(20);
      tests_run++;
      if (rsp_count[0] != n0 + 1 || last_rsp[0] !== {8'h00, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL single_add: got %h (count %0d), want 002 (count %0d)",
                  last_rsp[0], rsp_count[0], n0 + 1);
      end
      tests_run++;
      if (rsp_count[1] != n1) begin
         tests_failed++;
         $display("FAIL single_port1_quiet: got %0d responses, want %0d", rsp_count[1], n1);
      end
   endtask

   task automatic test_arbitration();
      int  g0;
      bit  alt_ok, gap_ok;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      tick();
      rst_n = 1'b0;
      req_q0.push_back({4'h1, 8'h03, 8'h05});
      req_q1.push_back({4'h4, 8'hA5, 8'h0F});
      g0 = grant_log.size();
      tick(); tick();
      rst_n = 1'b1;
      wait_drain(30);
      tests_run++;
      if (grant_log.size() < g0 + 2 || grant_log[g0] != 0 || grant_log[g0+1] != 1) begin
         tests_failed++;
         $display("FAIL arb_order: got first grant %0d, want 0 then 1",
                  grant_log.size() > g0 ? grant_log[g0] : -1);
      end else begin
         tests_run++;
         if (acc_cyc_log[g0+1] - acc_cyc_log[g0] != 3) begin
            tests_failed++;
            $display("FAIL arb_spacing: got %0d cycles, want 3", acc_cyc_log[g0+1] - acc_cyc_log[g0]);
         end
      end
      tests_run++;
      if (last_rsp[0] !== {8'hFE, 1'b1, 1'b0} || last_rsp[1] !== {8'hAA, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL arb_results: got p0 %h p1 %h, want p0 3fa p1 2a8", last_rsp[0], last_rsp[1]);
      end

      g0 = grant_log.size();
      for (int i = 0; i < 10; i++) begin
         req_q0.push_back({4'($urandom_range(0, 7)), 8'($urandom), 8'($urandom)});
         req_q1.push_back({4'($urandom_range(0, 7)), 8'($urandom), 8'($urandom)});
      end
      wait_drain(200);
      alt_ok = (grant_log.size() == g0 + 20);
      gap_ok = alt_ok;
      if (alt_ok) begin
         for (int i = 0; i < 20; i++) begin
            if (grant_log[g0+i] != (i % 2)) alt_ok = 1'b0;
            if (i > 0 && acc_cyc_log[g0+i] - acc_cyc_log[g0+i-1] != 3) gap_ok = 1'b0;
         end
      end
      tests_run++;
      if (!alt_ok) begin
         tests_failed++;
         $display("FAIL b2b_alternate: got %0d grants with order broken, want 20 alternating",
                  grant_log.size() - g0);
      end
      tests_run++;
      if (!gap_ok) begin
         tests_failed++;
         $display("FAIL b2b_throughput: got accept spacing not 3, want 3 cycles");
      end
   endtask

   task automatic test_backpressure();
      int a0, n;
      rsp0_ready = 1'b1; rsp1_ready = 1'b0;
      a0 = acc_count;
      req_q1.push_back({4'h7, 8'h03, 8'h11});
      n = 0;
      while (!rsp1_valid && n < 20) begin
         sample();
         n++;
      end
      tests_run++;
      if (!rsp1_valid) begin
         tests_failed++;
         $display("FAIL bp_valid_timeout: got rsp1_valid 0, want 1 within 20 cycles");
      end
      req_q0.push_back({4'h0, 8'h10, 8'h20});
      for (int k = 0; k < 5; k++) begin
         tests_run++;
         if ({rsp1_valid, rsp0_valid, rsp1_out, rsp1_carry, req0_ready, req1_ready} !==
             {1'b1, 1'b0, 8'h88, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL bp_hold cycle %0d: got v1 %b v0 %b out %h c %b rdy %b%b, want 1 0 88 0 00",
                     k, rsp1_valid, rsp0_valid, rsp1_out, rsp1_carry, req0_ready, req1_ready);
         end
         sample();
      end
      tests_run++;
      if (acc_count != a0 + 1) begin
         tests_failed++;
         $display("FAIL bp_no_accept: got %0d accepts, want %0d", acc_count - a0, 1);
      end
      @(posedge clk); #1;
      rsp1_ready = 1'b1;
      wait_drain(30);
      tests_run++;
      if (last_rsp[1] !== {8'h88, 1'b0, 1'b0} || last_rsp[0] !== {8'h30, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL bp_results: got p1 %h p0 %h, want p1 220 p0 0c0", last_rsp[1], last_rsp[0]);
      end
      tests_run++;
      if (acc_cycle[0] - hs_cycle[1] != 1) begin
         tests_failed++;
         $display("FAIL bp_next_accept: got %0d cycles after handshake, want 1",
                  acc_cycle[0] - hs_cycle[1]);
      end
   endtask

   task automatic test_illegal();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req_q0.push_back({4'hC, 8'h12, 8'h34});
      wait_drain(20);
      tests_run++;
      if (last_rsp[0] !== illegal_expect()) begin
         tests_failed++;
         $display("FAIL illegal_op: got %h, want %h", last_rsp[0], illegal_expect());
      end
      req_q0.push_back({4'h0, 8'h01, 8'h01});
      wait_drain(20);
      tests_run++;
      if (last_rsp[0] !== {8'h02, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL legal_after_illegal: got %h, want 008", last_rsp[0]);
      end
   endtask

   task automatic test_reset_mid_op();
      int a0, n, r0, g0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      a0 = acc_count;
      req_q0.push_back({4'h0, 8'h40, 8'h40});
      n = 0;
      while (acc_count == a0 && n < 20) begin
         sample();
         n++;
      end
      @(posedge clk); #1;
      tests_run++;
      if (busy !== 1'b1 || rsp0_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_exec_state: got busy %b valid %b, want busy 1 valid 0", busy, rsp0_valid);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tests_run++;
      if (exp_q0.size() != 1) begin
         tests_failed++;
         $display("FAIL mid_inflight: got %0d pending, want 1", exp_q0.size());
      end
      exp_q0.delete();
      r0 = rsp_count[0];
      sample();
      tests_run++;
      if ({busy, rsp0_valid, rsp0_out, rsp0_carry, rsp0_err, alu_ctrl, alu_x, alu_y} !== 32'h0) begin
         tests_failed++;
         $display("FAIL mid_reset_outputs: got busy %b v %b out %h c %b e %b alu %h %h %h, want all 0",
                  busy, rsp0_valid, rsp0_out, rsp0_carry, rsp0_err, alu_ctrl, alu_x, alu_y);
      end
      sample(); sample(); sample();
      tests_run++;
      if (rsp_count[0] != r0) begin
         tests_failed++;
         $display("FAIL mid_discard: got %0d responses, want %0d", rsp_count[0], r0);
      end
      g0 = grant_log.size();
      req_q0.push_back({4'h2, 8'hF0, 8'h3C});
      req_q1.push_back({4'h3, 8'h0F, 8'h30});
      wait_drain(30);
      tests_run++;
      if (grant_log.size() < g0 + 2 || grant_log[g0] != 0) begin
         tests_failed++;
         $display("FAIL mid_fresh_priority: got first grant %0d, want 0",
                  grant_log.size() > g0 ? grant_log[g0] : -1);
      end
      tests_run++;
      if (last_rsp[0] !== {8'h30, 1'b0, 1'b0} || last_rsp[1] !== {8'h3F, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL mid_fresh_results: got p0 %h p1 %h, want p0 0c0 p1 0fc", last_rsp[0], last_rsp[1]);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      for (int p = 0; p < 2; p++) begin
         acc_cycle[p] = 0; hs_cycle[p] = 0; rsp_count[p] = 0;
         last_rsp[p] = '0; prev_valid[p] = 1'b0;
      end
      test_reset();
      test_single_op();
      test_arbitration();
      test_backpressure();
      test_illegal();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/alu_sched.md
# alu_sched

Two-port round-robin scheduler that shares one 8-bit combinational ALU (4-bit `ctrl`, `x`, `y` → `out`, `carry`) between two requesters. It accepts one operation at a time over a valid/ready handshake, registers the operands onto the ALU, captures the result, and returns it to the originating port over a valid/ready response channel. It sits between the two datapath clients and the shared ALU instance.

## Interface
- `FIRST_PORT`, default 0: port that wins the first simultaneous-request arbitration after reset (0 or 1).
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `req0_valid` input 1: port 0 has an operation pending.
- `req0_ready` output 1: port 0 operation accepted this cycle.
- `req0_ctrl` input 4: port 0 ALU opcode.
- `req0_x`, `req0_y` input 8: port 0 operands.
- `req1_valid`, `req1_ready`, `req1_ctrl`, `req1_x`, `req1_y`: same as port 0, for port 1.
- `rsp0_valid` output 1: port 0 result available.
- `rsp0_ready` input 1: port 0 consumes the result.
- `rsp0_out` output 8: port 0 result.
- `rsp0_carry` output 1: port 0 carry/borrow.
- `rsp0_err` output 1: port 0 illegal-opcode flag (see Configuration).
- `rsp1_valid`, `rsp1_ready`, `rsp1_out`, `rsp1_carry`, `rsp1_err`: same as port 0, for port 1.
- `alu_ctrl` output 4: opcode driven to the shared ALU.
- `alu_x`, `alu_y` output 8: operands driven to the shared ALU.
- `alu_out` input 8: ALU result.
- `alu_carry` input 1: ALU carry.
- `busy` output 1: high whenever state ≠ IDLE.

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE:**
  - Arbitrate among asserted `reqN_valid`.
  - If exactly one port is valid, grant it.
  - If both are valid, grant the port ≠ `last_grant`.
  - `reqN_ready` is combinational: 1 only in IDLE and only for the granted port.
  - On the handshake, latch ctrl/x/y into the operand register, record `grant`, and go to EXEC.
  - If no port is valid, stay in IDLE.
- **EXEC:**
  - Operand register drives `alu_ctrl`/`alu_x`/`alu_y`.
  - At end of cycle, capture `alu_out` and `alu_carry` into the result register; set `err` if illegal.
  - Go to RESP.
- **RESP:**
  - `rspN_valid` = 1 for the granted port only; the other port's `rspN_valid` = 0.
  - Result, carry, and err are held stable until `rspN_ready`.
  - On the handshake: `last_grant` ← `grant`, then go to IDLE.
  - While in RESP, `rspN_ready` from the non-granted port is ignored.
- **Operand hold:** the ALU inputs hold the operand register in all states and update only on accept.
- **Passthrough:** `rspN_out`/`carry` are the result register (shared); the granted-port valid steers ownership.
- **Arithmetic:** no arithmetic is performed in this block. Result and carry are passed through bit-exact from the ALU (ADD carry-out, SUB borrow as 9th bit).
- **Requester rule:** a requester must hold `reqN_valid` and its operands stable until `reqN_ready`; the block does not check this.

## Timing
- **Reset:** `rst_n` low at a rising edge gives:
  - state = IDLE;
  - all `reqN_ready`, `rspN_valid`, `rspN_err`, `busy` = 0;
  - `rspN_out` = 0x00, `rspN_carry` = 0;
  - `alu_ctrl`/`alu_x`/`alu_y` = 0;
  - `last_grant` = ~`FIRST_PORT`.
- **Reset mid-operation:** an in-flight op in EXEC or RESP is discarded, no response is issued, and `last_grant` reinitialises.
- **Latency:** accept at cycle T; `rspN_valid` first high at T+2.
- **Throughput:** with `rspN_ready` held high, the response handshake occurs at T+2 and the next accept at T+3, so the peak is one op per 3 cycles.
- **Fairness:** with both ports continuously valid, grants alternate 0,1,0,1… (starting with `FIRST_PORT`). Neither port waits more than one operation.
- **Fresh arbitration:** a request arriving during EXEC/RESP waits; arbitration is re-evaluated in the IDLE cycle after the response handshake.
- **Simultaneous events:** a `reqN_valid` that rises in the same cycle as a response handshake is not accepted until the next cycle (IDLE).

## Configuration
- **Macro:** `ALU_SCHED_ILLEGAL_CHK_EN`.
- **Defined:**
  - ctrl values 4'hC–4'hF are accepted normally but flagged.
  - In EXEC the result register is forced to out = 0x00, carry = 0, err = 1, ignoring the ALU inputs.
  - Legal opcodes give err = 0.
- **Undefined:**
  - `rspN_err` is tied to 0.
  - All opcodes pass the ALU output through unchanged (ALU default 0x00 / carry 0).

## Test plan
- **Single op:** port 0 ADD (ctrl 0x0) x = 0xFF, y = 0x01, `rsp0_ready` = 1 → `req0_ready` at T, `rsp0_valid` at T+2 with out = 0x00, carry = 1; `rsp1_valid` stays 0.
- **Arbitration:** both ports valid at the first cycle after reset with `FIRST_PORT` = 0. Port 0 does SUB x = 0x03, y = 0x05; port 1 does XOR x = 0xA5, y = 0x0F. Required:
  - port 0 granted first → out = 0xFE, carry = 1;
  - port 1 accepted at T+3 → out = 0xAA, carry = 0.
  - Continuing 10 back-to-back requests per port alternates grants strictly.
- **Backpressure:** port 1 SHL ctrl 0x7 x = 0x03, y = 0x11 with `rsp1_ready` low for 5 cycles → `rsp1_valid` high and out = 0x88 stable for all 5 cycles; no new accept on either port until the handshake.
- **Illegal opcode:** port 0 ctrl 0xC → with the macro defined, out = 0x00, carry = 0, err = 1; without it, err = 0, out = 0x00.
- **Reset mid-op:** `rst_n` low for one edge while in EXEC → next cycle `busy` = 0, `rsp0_valid` = 0, outputs at reset values. A fresh request then completes normally with the `FIRST_PORT` priority.
